// File: rtl/sync_hs_src.sv
`default_nettype none
// ============================================================================
//  Module   : sync_hs_src
//  Purpose  : Source side of a two-phase (toggle) handshake clock-domain
//             crossing. A word accepted in the clka domain is held on
//             req_data while req_tgl flips; the far domain answers by
//             toggling ack_tgl back, which is resynchronized here and
//             reported as a one-cycle done pulse.
//  Options  : `define SYNC_HS_SRC_TIMEOUT_EN builds a saturating 16-bit
//             wait counter and the sticky timeout flag. Without it timeout
//             is tied low and no counter exists.
//  Ports    : clka, clka_rst_n        - clock / async active-low reset
//             src_valid, src_data     - word offered by the local side
//             src_ready               - high in IDLE (combinational)
//             req_data, req_tgl       - registered request to far domain
//             ack_tgl                 - async acknowledge toggle
//             done                    - one-cycle completion pulse
//             busy                    - registered, high in WAIT_ACK
//             timeout                 - sticky overdue-ack flag
//  Revision : 1.0  initial release
// ============================================================================
module sync_hs_src #(
  parameter int DATA_W      = 16,
  parameter int SYNC_STAGE  = 2,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic              clka,
  input  logic              clka_rst_n,
  input  logic              src_valid,
  input  logic [DATA_W-1:0] src_data,
  output logic              src_ready,
  output logic [DATA_W-1:0] req_data,
  output logic              req_tgl,
  input  logic              ack_tgl,
  output logic              done,
  output logic              busy,
  output logic              timeout
);

  typedef enum logic [0:0] {
    IDLE     = 1'b0,
    WAIT_ACK = 1'b1
  } state_t;

  localparam logic [15:0] C_TO_LAST = 16'(TIMEOUT_CYC - 1);

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [SYNC_STAGE-1:0]   r_ack_sync;
  logic                    w_ack_s;
  logic                    w_accept;
  logic                    w_ack_match;
  logic                    w_complete;
  logic                    r_req_tgl;
  logic [DATA_W-1:0]       r_req_data;
  logic                    r_done;
  logic                    r_busy;

  // ack_tgl enters only through this shift chain; nothing else looks at it.
  always_ff @(posedge clka or negedge clka_rst_n) begin
    if (!clka_rst_n) r_ack_sync <= '0;
    else             r_ack_sync <= {r_ack_sync[SYNC_STAGE-2:0], ack_tgl};
  end

  assign w_ack_s = r_ack_sync[SYNC_STAGE-1];

  // Phases agree once the far side has echoed our latest toggle.
  assign w_ack_match = (w_ack_s == r_req_tgl);

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_complete  = 1'b0;
    case (r_state)
      IDLE: begin
        if (src_valid) begin
          w_accept    = 1'b1;
          w_state_nxt = WAIT_ACK;
        end
      end
      WAIT_ACK: begin
        if (w_ack_match) begin
          w_complete  = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clka or negedge clka_rst_n) begin
    if (!clka_rst_n) r_state <= IDLE;
    else             r_state <= w_state_nxt;
  end

  always_ff @(posedge clka or negedge clka_rst_n) begin
    if (!clka_rst_n) begin
      r_req_tgl  <= 1'b0;
      r_req_data <= '0;
      r_done     <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_done <= w_complete;
      if (w_accept) begin
        r_req_data <= src_data;
        r_req_tgl  <= ~r_req_tgl;
        r_busy     <= 1'b1;
      end else if (w_complete) begin
        r_busy <= 1'b0;
      end
    end
  end

`ifdef SYNC_HS_SRC_TIMEOUT_EN
  logic [15:0] r_to_cnt;
  logic        r_timeout;

  always_ff @(posedge clka or negedge clka_rst_n) begin
    if (!clka_rst_n) begin
      r_to_cnt <= '0;
    end else if (w_accept) begin
      r_to_cnt <= '0;
    end else if ((r_state == WAIT_ACK) && (r_to_cnt != 16'hFFFF)) begin
      r_to_cnt <= r_to_cnt + 16'd1;
    end
  end

  // Sticky until the completing edge; completion wins over a same-edge set.
  always_ff @(posedge clka or negedge clka_rst_n) begin
    if (!clka_rst_n) begin
      r_timeout <= 1'b0;
    end else if (w_complete) begin
      r_timeout <= 1'b0;
    end else if ((r_state == WAIT_ACK) && (r_to_cnt == C_TO_LAST)) begin
      r_timeout <= 1'b1;
    end
  end

  assign timeout = r_timeout;
`else
  logic w_unused_timeout_cfg;
  assign w_unused_timeout_cfg = &{1'b0, C_TO_LAST};
  assign timeout = 1'b0;
`endif

  assign src_ready = (r_state == IDLE);
  assign req_data  = r_req_data;
  assign req_tgl   = r_req_tgl;
  assign done      = r_done;
  assign busy      = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_sync_hs_src.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sync_hs_src
//  Purpose  : Directed self-checking bench for sync_hs_src (SYNC_STAGE=2,
//             TIMEOUT_CYC=8). The bench plays the far side by driving
//             ack_tgl by hand.
//  Revision : 1.0  initial release
// ============================================================================
module tb_sync_hs_src;

  logic        clka = 1'b0;
  logic        clka_rst_n;
  logic        src_valid;
  logic [15:0] src_data;
  logic        src_ready;
  logic [15:0] req_data;
  logic        req_tgl;
  logic        ack_tgl;
  logic        done;
  logic        busy;
  logic        timeout;

  int n_cmp = 0;
  int n_bad = 0;
  logic exp_tgl;

  sync_hs_src #(
    .DATA_W     (16),
    .SYNC_STAGE (2),
    .TIMEOUT_CYC(8)
  ) dut (
    .clka      (clka),
    .clka_rst_n(clka_rst_n),
    .src_valid (src_valid),
    .src_data  (src_data),
    .src_ready (src_ready),
    .req_data  (req_data),
    .req_tgl   (req_tgl),
    .ack_tgl   (ack_tgl),
    .done      (done),
    .busy      (busy),
    .timeout   (timeout)
  );

  always #5 clka = ~clka;

  // Advance one edge and settle; inputs change and outputs are read here.
  task automatic step();
    @(posedge clka);
    #1;
  endtask

  // Bounded wait for done; returns 1 if seen (positioned in the done cycle).
  task automatic wait_done(output bit seen);
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (done === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    clka_rst_n = 1'b0;
    src_valid  = 1'b0;
    src_data   = 16'h0;
    ack_tgl    = 1'b1;
    exp_tgl    = 1'b0;
    repeat (3) step();
    n_cmp++; if (req_tgl !== 1'b0)    begin n_bad++; $display("FAIL rst_req_tgl got=%b exp=0", req_tgl); end
    n_cmp++; if (src_ready !== 1'b1)  begin n_bad++; $display("FAIL rst_src_ready got=%b exp=1", src_ready); end
    n_cmp++; if (busy !== 1'b0)       begin n_bad++; $display("FAIL rst_busy got=%b exp=0", busy); end
    n_cmp++; if (done !== 1'b0)       begin n_bad++; $display("FAIL rst_done got=%b exp=0", done); end
    n_cmp++; if (req_data !== 16'h0)  begin n_bad++; $display("FAIL rst_req_data got=%h exp=0000", req_data); end
    n_cmp++; if (timeout !== 1'b0)    begin n_bad++; $display("FAIL rst_timeout got=%b exp=0", timeout); end
    clka_rst_n = 1'b1;
    // ack_s becomes 1 != req_tgl while IDLE: must stay quiet.
    for (int i = 0; i < 5; i++) begin
      step();
      n_cmp++;
      if (done !== 1'b0 || busy !== 1'b0 || src_ready !== 1'b1) begin
        n_bad++;
        $display("FAIL spurious_ack cyc=%0d got done=%b busy=%b rdy=%b exp 0/0/1", i, done, busy, src_ready);
      end
    end
    ack_tgl = 1'b0;
    repeat (3) step();
  endtask

  task automatic test_single();
    src_valid = 1'b1;
    src_data  = 16'hA5C3;
    step();                       // edge N: accept
    src_valid = 1'b0;
    exp_tgl   = ~exp_tgl;
    n_cmp++; if (req_tgl !== exp_tgl)     begin n_bad++; $display("FAIL single_tgl got=%b exp=%b", req_tgl, exp_tgl); end
    n_cmp++; if (req_data !== 16'hA5C3)   begin n_bad++; $display("FAIL single_data got=%h exp=a5c3", req_data); end
    n_cmp++; if (busy !== 1'b1 || src_ready !== 1'b0) begin n_bad++; $display("FAIL single_busy got busy=%b rdy=%b exp 1/0", busy, src_ready); end
    step(); step();
    ack_tgl = exp_tgl;            // changes between k-1 and k
    step();                       // edge k
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL single_done_k got=%b exp=0", done); end
    step();                       // edge k+1
    n_cmp++; if (done !== 1'b0 || busy !== 1'b1) begin n_bad++; $display("FAIL single_k1 got done=%b busy=%b exp 0/1", done, busy); end
    step();                       // edge k+2
    n_cmp++; if (done !== 1'b1 || busy !== 1'b0 || src_ready !== 1'b1) begin n_bad++; $display("FAIL single_k2 got done=%b busy=%b rdy=%b exp 1/0/1", done, busy, src_ready); end
    step();                       // edge k+3
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL single_done_fall got=%b exp=0", done); end
  endtask

  task automatic test_back_to_back();
    bit seen;
    src_valid = 1'b1;
    src_data  = 16'h0001;
    step();
    exp_tgl  = ~exp_tgl;
    src_data = 16'h0002;
    n_cmp++; if (req_data !== 16'h0001 || req_tgl !== exp_tgl) begin n_bad++; $display("FAIL b2b_first got data=%h tgl=%b exp 0001/%b", req_data, req_tgl, exp_tgl); end
    ack_tgl = exp_tgl;
    wait_done(seen);
    n_cmp++; if (!seen) begin n_bad++; $display("FAIL b2b_done_timeout got=none exp=done"); end
    n_cmp++; if (req_data !== 16'h0001 || src_ready !== 1'b1) begin n_bad++; $display("FAIL b2b_done_cycle got data=%h rdy=%b exp 0001/1", req_data, src_ready); end
    step();                       // second accept taken in the done cycle
    src_valid = 1'b0;
    exp_tgl   = ~exp_tgl;
    n_cmp++; if (req_data !== 16'h0002 || req_tgl !== exp_tgl || busy !== 1'b1 || done !== 1'b0) begin
      n_bad++; $display("FAIL b2b_second got data=%h tgl=%b busy=%b done=%b exp 0002/%b/1/0", req_data, req_tgl, busy, done, exp_tgl);
    end
    ack_tgl = exp_tgl;
    wait_done(seen);
    n_cmp++; if (!seen) begin n_bad++; $display("FAIL b2b_done2_timeout got=none exp=done"); end
    step();
  endtask

  task automatic test_stability();
    bit seen;
    src_valid = 1'b1;
    src_data  = 16'h1234;
    step();
    exp_tgl = ~exp_tgl;
    for (int i = 0; i < 6; i++) begin
      src_data = 16'hF000 + 16'(i);
      step();
      n_cmp++;
      if (req_data !== 16'h1234 || src_ready !== 1'b0) begin
        n_bad++; $display("FAIL stable cyc=%0d got data=%h rdy=%b exp 1234/0", i, req_data, src_ready);
      end
    end
    src_valid = 1'b0;
    ack_tgl   = exp_tgl;
    wait_done(seen);
    n_cmp++; if (!seen || req_data !== 16'h1234) begin n_bad++; $display("FAIL stable_done got seen=%b data=%h exp 1/1234", seen, req_data); end
    step();
  endtask

  task automatic test_reset_mid();
    bit seen;
    src_valid = 1'b1;
    src_data  = 16'hBEEF;
    step();
    src_valid = 1'b0;
    step();
    #2;
    clka_rst_n = 1'b0;            // asserted between edges
    ack_tgl    = 1'b0;            // far side shares the reset
    exp_tgl    = 1'b0;
    #1;
    n_cmp++; if (req_tgl !== 1'b0 || busy !== 1'b0 || req_data !== 16'h0 || src_ready !== 1'b1 || done !== 1'b0) begin
      n_bad++; $display("FAIL midrst got tgl=%b busy=%b data=%h rdy=%b done=%b exp 0/0/0000/1/0", req_tgl, busy, req_data, src_ready, done);
    end
    step(); step();
    clka_rst_n = 1'b1;
    step();
    src_valid = 1'b1;
    src_data  = 16'h5A5A;
    step();
    src_valid = 1'b0;
    exp_tgl   = ~exp_tgl;
    n_cmp++; if (req_tgl !== exp_tgl || req_data !== 16'h5A5A) begin n_bad++; $display("FAIL midrst_next got tgl=%b data=%h exp %b/5a5a", req_tgl, req_data, exp_tgl); end
    ack_tgl = exp_tgl;
    wait_done(seen);
    n_cmp++; if (!seen) begin n_bad++; $display("FAIL midrst_done got=none exp=done"); end
    step();
  endtask

  task automatic test_timeout();
    bit seen;
    logic exp_to;
`ifdef SYNC_HS_SRC_TIMEOUT_EN
    exp_to = 1'b1;
`else
    exp_to = 1'b0;
`endif
    src_valid = 1'b1;
    src_data  = 16'h7777;
    step();                       // edge N
    src_valid = 1'b0;
    exp_tgl   = ~exp_tgl;
    for (int i = 1; i <= 7; i++) begin
      step();
      n_cmp++; if (timeout !== 1'b0) begin n_bad++; $display("FAIL to_early cyc=%0d got=%b exp=0", i, timeout); end
    end
    step();                       // edge N+8
    n_cmp++; if (timeout !== exp_to) begin n_bad++; $display("FAIL to_set got=%b exp=%b", timeout, exp_to); end
    n_cmp++; if (busy !== 1'b1 || src_ready !== 1'b0) begin n_bad++; $display("FAIL to_state got busy=%b rdy=%b exp 1/0", busy, src_ready); end
    ack_tgl = exp_tgl;
    step(); step();               // k, k+1: still flagged
    n_cmp++; if (timeout !== exp_to || done !== 1'b0) begin n_bad++; $display("FAIL to_hold got to=%b done=%b exp %b/0", timeout, done, exp_to); end
    step();                       // k+2: done and clear together
    n_cmp++; if (done !== 1'b1 || timeout !== 1'b0) begin n_bad++; $display("FAIL to_clear got done=%b to=%b exp 1/0", done, timeout); end
    step();
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_stability();
    test_reset_mid();
    test_timeout();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
